// File: rtl/key_conditioner.sv
// key_conditioner: push-button front end for the timer controller.
// Each raw active-low key is synchronized, debounced and turned into a clean
// level plus single-cycle press/release pulses. All outputs are registered.
// Optional feature macro: KEY_COND_REPEAT_EN adds auto-repeat press pulses
// while a key stays held (REPEAT_DELAY to the first, then every REPEAT_PERIOD).
module key_conditioner #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2, REPEAT_* must be >= 1");
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_pressed;
    logic            r_press_pulse;
    logic            r_release_pulse;
    logic            w_repeat_fire;

    // Two-flop synchronizer on the inverted (active-high) raw key level.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
        // giving two real flops; blocking here would collapse the chain.
        r_sync1 <= ~key_n[k];
        r_sync2 <= r_sync1;
      end
    end

    // Debounce: accept the synchronized level only after it has differed
    // from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_db_cnt <= '0;
        r_stable <= 1'b0;
      end else if (r_sync2 == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_stable <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

`ifdef KEY_COND_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_first;
    logic             w_rep_active;
    logic [REP_W-1:0] w_rep_last;

    // Repeat only while the key is held and not already falling, so no
    // repeat pulse can coincide with or follow the release.
    assign w_rep_active  = r_pressed & r_stable;
    assign w_rep_last    = r_rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST;
    assign w_repeat_fire = w_rep_active && (r_rep_cnt == w_rep_last);

    // Repeat timer: long first interval after the initial press, then the
    // shorter period; idle and cleared whenever the key is not held.
    always_ff @(posedge clk) begin
      if (reset || !w_rep_active) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b1;
      end else if (w_repeat_fire) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
`else
    assign w_repeat_fire = 1'b0;
`endif

    // Output stage: registered level and edge pulses of the accepted level.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_pressed       <= 1'b0;
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
      end else begin
        r_pressed       <= r_stable;
        r_press_pulse   <= (r_stable & ~r_pressed) | w_repeat_fire;
        r_release_pulse <= ~r_stable & r_pressed;
      end
    end

    assign pressed[k]       = r_pressed;
    assign press_pulse[k]   = r_press_pulse;
    assign release_pulse[k] = r_release_pulse;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: self-checking bench for key_conditioner with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_KEYS=3.
// Expected outputs per edge are pushed to a scoreboard queue as stimulus is
// driven and popped when the outputs are sampled at the following negedge.
// Expectations follow KEY_COND_REPEAT_EN when it is defined.
module tb_key_conditioner;

  localparam int NK         = 3;
  localparam int DEBOUNCE   = 4;
  localparam int REP_DELAY  = 10;
  localparam int REP_PERIOD = 3;

  typedef struct packed {
    logic [NK-1:0] pr;
    logic [NK-1:0] pp;
    logic [NK-1:0] rp;
  } outs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] pressed;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  outs_t sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    edge_no  = 0;

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DEBOUNCE),
    .REPEAT_DELAY   (REP_DELAY),
    .REPEAT_PERIOD  (REP_PERIOD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // Auto-repeat pulse expected at edge e for a press accepted at press_e and
  // a release accepted at fall_e (pulses stop at the fall edge).
  function automatic logic exp_repeat(int e, int press_e, int fall_e);
`ifdef KEY_COND_REPEAT_EN
    if (e < press_e + REP_DELAY || e >= fall_e) return 1'b0;
    return ((e - press_e - REP_DELAY) % REP_PERIOD) == 0;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one edge worth of inputs, clock it, sample outputs mid-cycle.
  task automatic tick(input logic [NK-1:0] kn, input logic rst, output outs_t obs);
    key_n = kn;
    reset = rst;
    @(posedge clk);
    @(negedge clk);
    obs = '{pr: pressed, pp: press_pulse, rp: release_pulse};
  endtask

  // Two reset cycles with keys released; next tick is edge 0.
  task automatic do_reset();
    outs_t dummy;
    tick('1, 1'b1, dummy);
    tick('1, 1'b1, dummy);
    edge_no = 0;
  endtask

  task automatic test_reset();
    outs_t obs, exp;
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back('0);
      tick('1, (i < 3), obs);
      exp = sb_q.pop_front();
      n_checks++;
      if (obs !== exp)
        $display("FAIL reset cyc %0d: got pr=%b pp=%b rp=%b, want pr=%b pp=%b rp=%b",
                 i, obs.pr, obs.pp, obs.rp, exp.pr, exp.pp, exp.rp);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    outs_t obs, exp;
    do_reset();
    for (int e = 0; e <= 20; e++) begin
      exp = '0;
      exp.pr[1] = (e >= 6);
      exp.pp[1] = (e == 6) || exp_repeat(e, 6, 46);
      sb_q.push_back(exp);
      tick(3'b101, 1'b0, obs);
      edge_no++;
      exp = sb_q.pop_front();
      n_checks++;
      if (obs !== exp)
        $display("FAIL clean_press edge %0d: got pr=%b pp=%b rp=%b, want pr=%b pp=%b rp=%b",
                 e, obs.pr, obs.pp, obs.rp, exp.pr, exp.pp, exp.rp);
      else n_pass++;
    end
  endtask

  // Continues from test_clean_press without reset: key 1 released at edge 40.
  task automatic test_release();
    outs_t obs, exp;
    for (int e = edge_no; e <= 52; e++) begin
      exp = '0;
      exp.pr[1] = (e >= 6) && (e < 46);
      exp.pp[1] = exp_repeat(e, 6, 46);
      exp.rp[1] = (e == 46);
      sb_q.push_back(exp);
      tick((e < 40) ? 3'b101 : 3'b111, 1'b0, obs);
      edge_no++;
      exp = sb_q.pop_front();
      n_checks++;
      if (obs !== exp)
        $display("FAIL release edge %0d: got pr=%b pp=%b rp=%b, want pr=%b pp=%b rp=%b",
                 e, obs.pr, obs.pp, obs.rp, exp.pr, exp.pp, exp.rp);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    outs_t obs, exp;
    logic  k0_low;
    do_reset();
    for (int e = 0; e <= 20; e++) begin
      k0_low = (e <= 2) || (e >= 4 && e <= 6);
      sb_q.push_back('0);
      tick({2'b11, ~k0_low}, 1'b0, obs);
      exp = sb_q.pop_front();
      n_checks++;
      if (obs !== exp)
        $display("FAIL bounce edge %0d: got pr=%b pp=%b rp=%b, want all zero",
                 e, obs.pr, obs.pp, obs.rp);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    outs_t obs, exp;
    do_reset();
    for (int e = 0; e <= 15; e++) begin
      exp = '0;
      exp.pr[2] = (e >= 10);
      exp.pp[2] = (e == 10) || exp_repeat(e, 10, 1000);
      sb_q.push_back(exp);
      tick(3'b011, (e == 3), obs);
      exp = sb_q.pop_front();
      n_checks++;
      if (obs !== exp)
        $display("FAIL reset_mid edge %0d: got pr=%b pp=%b rp=%b, want pr=%b pp=%b rp=%b",
                 e, obs.pr, obs.pp, obs.rp, exp.pr, exp.pp, exp.rp);
      else n_pass++;
    end
  endtask

  task automatic test_auto_repeat();
    outs_t obs, exp;
    int    n_pp;
    int    want_pp;
    do_reset();
    n_pp = 0;
`ifdef KEY_COND_REPEAT_EN
    want_pp = 8;  // edges 6,16,19,22,25,28,31,34
`else
    want_pp = 1;
`endif
    for (int e = 0; e <= 40; e++) begin
      exp = '0;
      exp.pr[0] = (e >= 6) && (e < 36);
      exp.pp[0] = (e == 6) || exp_repeat(e, 6, 36);
      exp.rp[0] = (e == 36);
      sb_q.push_back(exp);
      tick((e <= 29) ? 3'b110 : 3'b111, 1'b0, obs);
      exp = sb_q.pop_front();
      if (obs.pp[0] === 1'b1) n_pp++;
      n_checks++;
      if (obs !== exp)
        $display("FAIL auto_repeat edge %0d: got pr=%b pp=%b rp=%b, want pr=%b pp=%b rp=%b",
                 e, obs.pr, obs.pp, obs.rp, exp.pr, exp.pp, exp.rp);
      else n_pass++;
    end
    n_checks++;
    if (n_pp !== want_pp)
      $display("FAIL auto_repeat pulse_count: got %0d, want %0d", n_pp, want_pp);
    else n_pass++;
  endtask

  // All keys pressed together, released together at edge 8.
  task automatic test_simultaneous();
    outs_t obs, exp;
    do_reset();
    for (int e = 0; e <= 17; e++) begin
      exp = '0;
      exp.pr = (e >= 6 && e < 14) ? 3'b111 : 3'b000;
      exp.pp = (e == 6) ? 3'b111 : 3'b000;
      exp.rp = (e == 14) ? 3'b111 : 3'b000;
      sb_q.push_back(exp);
      tick((e < 8) ? 3'b000 : 3'b111, 1'b0, obs);
      exp = sb_q.pop_front();
      n_checks++;
      if (obs !== exp)
        $display("FAIL simultaneous edge %0d: got pr=%b pp=%b rp=%b, want pr=%b pp=%b rp=%b",
                 e, obs.pr, obs.pp, obs.rp, exp.pr, exp.pp, exp.rp);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1;
    key_n = '1;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid_debounce();
    test_auto_repeat();
    test_simultaneous();
    n_checks++;
    if (sb_q.size() !== 0)
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
